// File: rtl/dma_desc_proc_mc.sv
//==============================================================================
// Module      : dma_desc_proc_mc
// Description : Multi-channel DMA descriptor processor. Each channel buffers
//               descriptors {id, len, wr_addr, rd_addr} in its own FIFO. A
//               round-robin arbiter picks a channel, and the descriptor is
//               split into read/write command pairs of at most MAX_CHUNK bytes.
//               A descriptor issues all of its chunks before the arbiter runs
//               again.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               desc_wr_i/desc_wrdata_i - per-channel descriptor push
//               desc_almost_full_o    - per-channel occupancy >= AF_LEVEL
//               desc_ovf_o            - per-channel sticky overflow flag
//               rd/wr_fifo_full_i     - downstream command FIFO back-pressure
//               rd_cmd_o/rd_addr_o/rd_bytes_o - read command
//               wr_cmd_o/wr_addr_o/wr_bytes_o - write command
//               cmd_id_o/cmd_ch_o/cmd_last_o  - command tag, channel, last chunk
//               desc_done_o           - descriptor completion pulse
//               busy_o                - engine not idle
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dma_desc_proc_mc #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int AF_LEVEL   = 24,
  parameter int MAX_CHUNK  = 4096,
  localparam int DESC_W    = ID_W + LEN_W + 2 * ADDR_W,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        desc_wr_i,
  input  logic [NUM_CH*DESC_W-1:0] desc_wrdata_i,
  output logic [NUM_CH-1:0]        desc_almost_full_o,
  output logic [NUM_CH-1:0]        desc_ovf_o,
  input  logic                     rd_fifo_full_i,
  input  logic                     wr_fifo_full_i,
  output logic                     rd_cmd_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  output logic [LEN_W-1:0]         rd_bytes_o,
  output logic                     wr_cmd_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [LEN_W-1:0]         wr_bytes_o,
  output logic [ID_W-1:0]          cmd_id_o,
  output logic [CH_W-1:0]          cmd_ch_o,
  output logic                     cmd_last_o,
  output logic                     desc_done_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] MAX_CHUNK_L = LEN_W'(MAX_CHUNK);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LATCH = 3'd2,
    S_CMD   = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0]        w_nempty;
  logic [NUM_CH-1:0]        w_pop;
  logic [NUM_CH*DESC_W-1:0] w_head;
  logic [DESC_W-1:0]        w_sel;
  logic [CH_W-1:0]          w_pick;
  logic                     w_any;
  logic                     w_bp;

  // grant_q doubles as the round-robin "last grant" pointer.
  logic [CH_W-1:0]   grant_q;
  logic [DESC_W-1:0] fifo_dout_q;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  rem_q;
  logic [ADDR_W-1:0] rda_q, wra_q;

  // Copies of the last issued command, shown on the outputs outside CMD.
  logic [ADDR_W-1:0] rda_h_q, wra_h_q;
  logic [LEN_W-1:0]  bytes_h_q;
  logic [ID_W-1:0]   id_h_q;
  logic [CH_W-1:0]   ch_h_q;

  logic [LEN_W-1:0] w_dlen;
  logic [LEN_W-1:0] w_chunk;
  logic             w_last;
  logic             w_in_cmd;

  //--------------------------------------------------------------------------
  // Per-channel descriptor FIFOs (registered read port)
  //--------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DESC_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       cnt_q;
    logic              ovf_q;
    logic              w_full;
    logic              w_push;

    assign w_pop[c]    = (state_q == S_POP) && (grant_q == CH_W'(c));
    assign w_full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a write on full is accepted.
    assign w_push      = desc_wr_i[c] && (!w_full || w_pop[c]);
    assign w_nempty[c] = (cnt_q != '0);
    assign w_head[c*DESC_W +: DESC_W] = mem_q[rptr_q];
    assign desc_almost_full_o[c] = (cnt_q >= (AW+1)'(AF_LEVEL));
    assign desc_ovf_o[c] = ovf_q;

    always_ff @(posedge clk) begin
      if (w_push) begin
        mem_q[wptr_q] <= desc_wrdata_i[c*DESC_W +: DESC_W];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (w_push) wptr_q <= wptr_q + AW'(1);
        if (w_pop[c]) rptr_q <= rptr_q + AW'(1);
        if (w_push && !w_pop[c])      cnt_q <= cnt_q + (AW+1)'(1);
        else if (!w_push && w_pop[c]) cnt_q <= cnt_q - (AW+1)'(1);
        if (desc_wr_i[c] && w_full && !w_pop[c]) ovf_q <= 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Arbitration and head-of-FIFO selection
  //--------------------------------------------------------------------------
  assign w_any = |w_nempty;
  assign w_bp  = rd_fifo_full_i || wr_fifo_full_i;

  // Scan from the farthest candidate toward grant+1 so the nearest wins.
  always_comb begin
    w_pick = grant_q;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (w_nempty[(int'(grant_q) + k) % NUM_CH]) begin
        w_pick = CH_W'((int'(grant_q) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == CH_W'(c)) w_sel = w_head[c*DESC_W +: DESC_W];
    end
  end

  assign w_dlen   = fifo_dout_q[2*ADDR_W +: LEN_W];
  assign w_chunk  = (rem_q > MAX_CHUNK_L) ? MAX_CHUNK_L : rem_q;
  assign w_last   = (w_chunk == rem_q);
  assign w_in_cmd = (state_q == S_CMD);

  //--------------------------------------------------------------------------
  // Control FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_any && !w_bp) state_d = S_POP;
      S_POP:   state_d = S_LATCH;
      S_LATCH: state_d = (w_dlen == '0) ? S_IDLE : S_CMD;
      S_CMD:   state_d = w_last ? S_IDLE : S_WAIT;
      S_WAIT:  if (!w_bp) state_d = S_CMD;
      default: state_d = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= CH_W'(NUM_CH - 1);
      fifo_dout_q <= '0;
      id_q        <= '0;
      rem_q       <= '0;
      rda_q       <= '0;
      wra_q       <= '0;
      rda_h_q     <= '0;
      wra_h_q     <= '0;
      bytes_h_q   <= '0;
      id_h_q      <= '0;
      ch_h_q      <= '0;
    end else begin
      if (state_q == S_IDLE && state_d == S_POP) grant_q <= w_pick;
      if (state_q == S_POP) fifo_dout_q <= w_sel;
      if (state_q == S_LATCH) begin
        rda_q <= fifo_dout_q[0 +: ADDR_W];
        wra_q <= fifo_dout_q[ADDR_W +: ADDR_W];
        rem_q <= w_dlen;
        id_q  <= fifo_dout_q[2*ADDR_W+LEN_W +: ID_W];
      end
      if (w_in_cmd) begin
        rem_q     <= rem_q - w_chunk;
        rda_q     <= rda_q + ADDR_W'(w_chunk);
        wra_q     <= wra_q + ADDR_W'(w_chunk);
        rda_h_q   <= rda_q;
        wra_h_q   <= wra_q;
        bytes_h_q <= w_chunk;
        id_h_q    <= id_q;
        ch_h_q    <= grant_q;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs: live values during CMD, held copies otherwise
  //--------------------------------------------------------------------------
  assign rd_cmd_o    = w_in_cmd;
  assign wr_cmd_o    = w_in_cmd;
  assign rd_addr_o   = w_in_cmd ? rda_q   : rda_h_q;
  assign wr_addr_o   = w_in_cmd ? wra_q   : wra_h_q;
  assign rd_bytes_o  = w_in_cmd ? w_chunk : bytes_h_q;
  assign wr_bytes_o  = w_in_cmd ? w_chunk : bytes_h_q;
  assign cmd_id_o    = w_in_cmd ? id_q    : id_h_q;
  assign cmd_ch_o    = w_in_cmd ? grant_q : ch_h_q;
  assign cmd_last_o  = w_in_cmd && w_last;
  assign desc_done_o = (w_in_cmd && w_last) || ((state_q == S_LATCH) && (w_dlen == '0));
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dma_desc_proc_mc.sv
//==============================================================================
// Module      : tb_dma_desc_proc_mc
// Description : Directed self-checking bench for dma_desc_proc_mc with default
//               parameters (2 channels, 32-bit addresses, 4096-byte chunks).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dma_desc_proc_mc;

  localparam int NUM_CH = 2;
  localparam int DESC_W = 8 + 16 + 2 * 32;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        desc_wr_i;
  logic [NUM_CH*DESC_W-1:0] desc_wrdata_i;
  logic [NUM_CH-1:0]        desc_almost_full_o;
  logic [NUM_CH-1:0]        desc_ovf_o;
  logic                     rd_fifo_full_i;
  logic                     wr_fifo_full_i;
  logic                     rd_cmd_o;
  logic [31:0]              rd_addr_o;
  logic [15:0]              rd_bytes_o;
  logic                     wr_cmd_o;
  logic [31:0]              wr_addr_o;
  logic [15:0]              wr_bytes_o;
  logic [7:0]               cmd_id_o;
  logic [0:0]               cmd_ch_o;
  logic                     cmd_last_o;
  logic                     desc_done_o;
  logic                     busy_o;

  int checks = 0;
  int passed = 0;

  dma_desc_proc_mc dut (
    .clk               (clk),
    .reset             (reset),
    .desc_wr_i         (desc_wr_i),
    .desc_wrdata_i     (desc_wrdata_i),
    .desc_almost_full_o(desc_almost_full_o),
    .desc_ovf_o        (desc_ovf_o),
    .rd_fifo_full_i    (rd_fifo_full_i),
    .wr_fifo_full_i    (wr_fifo_full_i),
    .rd_cmd_o          (rd_cmd_o),
    .rd_addr_o         (rd_addr_o),
    .rd_bytes_o        (rd_bytes_o),
    .wr_cmd_o          (wr_cmd_o),
    .wr_addr_o         (wr_addr_o),
    .wr_bytes_o        (wr_bytes_o),
    .cmd_id_o          (cmd_id_o),
    .cmd_ch_o          (cmd_ch_o),
    .cmd_last_o        (cmd_last_o),
    .desc_done_o       (desc_done_o),
    .busy_o            (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    desc_wr_i = '0;
    rd_fifo_full_i = 1'b0;
    wr_fifo_full_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle push; returns on the negedge after the write edge.
  task automatic push(input int ch, input logic [7:0] id, input logic [15:0] len,
                      input logic [31:0] wa, input logic [31:0] ra);
    @(negedge clk);
    desc_wr_i = '0;
    desc_wr_i[ch] = 1'b1;
    desc_wrdata_i[ch*DESC_W +: DESC_W] = {id, len, wa, ra};
    @(negedge clk);
    desc_wr_i = '0;
  endtask

  task automatic wait_cmd(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rd_cmd_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_o); else passed++;
    checks++; if ({rd_cmd_o, wr_cmd_o, desc_done_o, cmd_last_o} !== 4'b0) $display("FAIL reset_strobes: got %b want 0000", {rd_cmd_o, wr_cmd_o, desc_done_o, cmd_last_o}); else passed++;
    checks++; if ({desc_almost_full_o, desc_ovf_o} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {desc_almost_full_o, desc_ovf_o}); else passed++;
    checks++; if ({rd_addr_o, wr_addr_o, rd_bytes_o, cmd_id_o} !== 88'h0) $display("FAIL reset_data: got %h want 0", {rd_addr_o, wr_addr_o, rd_bytes_o, cmd_id_o}); else passed++;
  endtask

  task automatic test_single();
    apply_reset();
    push(0, 8'h05, 16'h0100, 32'h2000, 32'h1000);
    @(negedge clk);
    checks++; if (rd_cmd_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL single_pop: cmd %0b busy %0b want 0 1", rd_cmd_o, busy_o); else passed++;
    @(negedge clk);
    checks++; if (rd_cmd_o !== 1'b0) $display("FAIL single_latch: cmd %0b want 0", rd_cmd_o); else passed++;
    @(negedge clk);
    checks++; if (rd_cmd_o !== 1'b1 || wr_cmd_o !== 1'b1) $display("FAIL single_cmd: rd %0b wr %0b want 1 1", rd_cmd_o, wr_cmd_o); else passed++;
    checks++; if (rd_addr_o !== 32'h1000 || wr_addr_o !== 32'h2000) $display("FAIL single_addr: rd %h wr %h want 1000 2000", rd_addr_o, wr_addr_o); else passed++;
    checks++; if (rd_bytes_o !== 16'h0100 || wr_bytes_o !== 16'h0100) $display("FAIL single_bytes: rd %h wr %h want 0100", rd_bytes_o, wr_bytes_o); else passed++;
    checks++; if (cmd_id_o !== 8'h05 || cmd_ch_o !== 1'b0 || cmd_last_o !== 1'b1 || desc_done_o !== 1'b1) $display("FAIL single_tag: id %h ch %0d last %0b done %0b want 05 0 1 1", cmd_id_o, cmd_ch_o, cmd_last_o, desc_done_o); else passed++;
    @(negedge clk);
    checks++; if (rd_cmd_o !== 1'b0 || busy_o !== 1'b0 || desc_done_o !== 1'b0) $display("FAIL single_after: cmd %0b busy %0b done %0b want 0 0 0", rd_cmd_o, busy_o, desc_done_o); else passed++;
    checks++; if (rd_addr_o !== 32'h1000 || rd_bytes_o !== 16'h0100 || cmd_id_o !== 8'h05) $display("FAIL single_hold: addr %h bytes %h id %h want 1000 0100 05", rd_addr_o, rd_bytes_o, cmd_id_o); else passed++;
  endtask

  task automatic test_chunks();
    logic [15:0] exp_b [3];
    logic [31:0] exp_r [3];
    logic [31:0] exp_w [3];
    bit got;
    exp_b = '{16'd4096, 16'd4096, 16'd1808};
    exp_r = '{32'hFFFF_F000, 32'h0000_0000, 32'h0000_1000};
    exp_w = '{32'h0000_8000, 32'h0000_9000, 32'h0000_A000};
    apply_reset();
    push(0, 8'h22, 16'd10000, 32'h0000_8000, 32'hFFFF_F000);
    for (int i = 0; i < 3; i++) begin
      wait_cmd(10, got);
      checks++; if (got !== 1'b1) $display("FAIL chunk%0d_timeout: no command seen", i); else passed++;
      checks++; if (rd_bytes_o !== exp_b[i] || wr_bytes_o !== exp_b[i]) $display("FAIL chunk%0d_bytes: got %0d want %0d", i, rd_bytes_o, exp_b[i]); else passed++;
      checks++; if (rd_addr_o !== exp_r[i] || wr_addr_o !== exp_w[i]) $display("FAIL chunk%0d_addr: rd %h wr %h want %h %h", i, rd_addr_o, wr_addr_o, exp_r[i], exp_w[i]); else passed++;
      checks++; if (cmd_last_o !== (i == 2) || desc_done_o !== (i == 2)) $display("FAIL chunk%0d_last: last %0b done %0b want %0b", i, cmd_last_o, desc_done_o, (i == 2)); else passed++;
    end
    wait_cmd(10, got);
    checks++; if (got !== 1'b0) $display("FAIL chunk_extra: got extra command want none"); else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_id [4];
    logic [0:0] exp_ch [4];
    bit got;
    exp_id = '{8'h10, 8'h20, 8'h11, 8'h21};
    exp_ch = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    @(negedge clk);
    desc_wr_i = 2'b11;
    desc_wrdata_i = {8'h20, 16'd8, 32'h300, 32'h400, 8'h10, 16'd8, 32'h100, 32'h200};
    @(negedge clk);
    desc_wrdata_i = {8'h21, 16'd8, 32'h700, 32'h800, 8'h11, 16'd8, 32'h500, 32'h600};
    @(negedge clk);
    desc_wr_i = '0;
    for (int i = 0; i < 4; i++) begin
      wait_cmd(20, got);
      checks++; if (got !== 1'b1 || cmd_ch_o !== exp_ch[i] || cmd_id_o !== exp_id[i]) $display("FAIL rr%0d: got cmd %0b ch %0d id %h want ch %0d id %h", i, got, cmd_ch_o, cmd_id_o, exp_ch[i], exp_id[i]); else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit got;
    apply_reset();
    push(0, 8'h33, 16'h2000, 32'h0200, 32'h0100);
    wait_cmd(10, got);
    checks++; if (got !== 1'b1 || rd_bytes_o !== 16'h1000 || cmd_last_o !== 1'b0) $display("FAIL bp_first: got %0b bytes %h last %0b want 1 1000 0", got, rd_bytes_o, cmd_last_o); else passed++;
    wr_fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rd_cmd_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL bp_hold%0d: cmd %0b busy %0b want 0 1", i, rd_cmd_o, busy_o); else passed++;
    end
    wr_fifo_full_i = 1'b0;
    @(negedge clk);
    checks++; if (rd_cmd_o !== 1'b1 || rd_addr_o !== 32'h1100 || wr_addr_o !== 32'h1200 || cmd_last_o !== 1'b1) $display("FAIL bp_resume: cmd %0b rd %h wr %h last %0b want 1 1100 1200 1", rd_cmd_o, rd_addr_o, wr_addr_o, cmd_last_o); else passed++;
  endtask

  task automatic test_zero_len();
    bit got;
    apply_reset();
    push(1, 8'h44, 16'h0000, 32'h10, 32'h20);
    @(negedge clk);
    @(negedge clk);
    checks++; if (desc_done_o !== 1'b1 || rd_cmd_o !== 1'b0) $display("FAIL zero_done: done %0b cmd %0b want 1 0", desc_done_o, rd_cmd_o); else passed++;
    wait_cmd(8, got);
    checks++; if (got !== 1'b0 || busy_o !== 1'b0) $display("FAIL zero_nocmd: cmd %0b busy %0b want 0 0", got, busy_o); else passed++;
  endtask

  task automatic test_overflow();
    int n;
    logic [7:0] first_id, last_id;
    apply_reset();
    rd_fifo_full_i = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      push(0, 8'(i - 1), 16'd1, 32'h0, 32'h0);
      if (i == 23) begin
        checks++; if (desc_almost_full_o[0] !== 1'b0) $display("FAIL af_23: got %0b want 0", desc_almost_full_o[0]); else passed++;
      end
      if (i == 24) begin
        checks++; if (desc_almost_full_o[0] !== 1'b1) $display("FAIL af_24: got %0b want 1", desc_almost_full_o[0]); else passed++;
      end
      if (i == 32) begin
        checks++; if (desc_ovf_o !== 2'b00) $display("FAIL ovf_32: got %b want 00", desc_ovf_o); else passed++;
      end
      if (i == 33) begin
        checks++; if (desc_ovf_o !== 2'b01) $display("FAIL ovf_33: got %b want 01", desc_ovf_o); else passed++;
      end
    end
    rd_fifo_full_i = 1'b0;
    n = 0;
    first_id = 8'hFF;
    last_id = 8'hFF;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rd_cmd_o === 1'b1) begin
        if (n == 0) first_id = cmd_id_o;
        last_id = cmd_id_o;
        n++;
      end
    end
    checks++; if (n != 32) $display("FAIL ovf_drain_count: got %0d want 32", n); else passed++;
    checks++; if (first_id !== 8'd0 || last_id !== 8'd31) $display("FAIL ovf_drain_ids: first %0d last %0d want 0 31", first_id, last_id); else passed++;
    checks++; if (desc_ovf_o !== 2'b01 || desc_almost_full_o !== 2'b00) $display("FAIL ovf_sticky: ovf %b af %b want 01 00", desc_ovf_o, desc_almost_full_o); else passed++;
  endtask

  task automatic test_reset_mid();
    bit got;
    apply_reset();
    push(0, 8'h55, 16'h3000, 32'h9000, 32'h8000);
    push(1, 8'h66, 16'd16, 32'hA000, 32'hB000);
    wait_cmd(10, got);
    checks++; if (got !== 1'b1 || cmd_id_o !== 8'h55) $display("FAIL mid_first: got %0b id %h want 1 55", got, cmd_id_o); else passed++;
    wr_fifo_full_i = 1'b1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b1 || rd_cmd_o !== 1'b0) $display("FAIL mid_wait: busy %0b cmd %0b want 1 0", busy_o, rd_cmd_o); else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr_fifo_full_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || rd_addr_o !== 32'h0 || rd_bytes_o !== 16'h0) $display("FAIL mid_reset: busy %0b addr %h bytes %h want 0 0 0", busy_o, rd_addr_o, rd_bytes_o); else passed++;
    wait_cmd(20, got);
    checks++; if (got !== 1'b0 || busy_o !== 1'b0) $display("FAIL mid_nocmd: cmd %0b busy %0b want 0 0", got, busy_o); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    desc_wr_i = '0;
    desc_wrdata_i = '0;
    rd_fifo_full_i = 1'b0;
    wr_fifo_full_i = 1'b0;
    test_reset();
    test_single();
    test_chunks();
    test_round_robin();
    test_backpressure();
    test_zero_len();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
